// File: rtl/recv_buffer_delete_arbiter_if.sv
// Handshake bundle between the commit-side requesters, the delete arbiter and
// the receive packet buffer. The arbiter uses the slave view; the environment
// (requesters plus packet buffer) uses the master view.
`ifndef QP_NUM_LOG
`define QP_NUM_LOG 12
`endif
`ifndef PSN_WIDTH
`define PSN_WIDTH 24
`endif
`ifndef RECV_BUFFER_SLOT_NUM_LOG
`define RECV_BUFFER_SLOT_NUM_LOG 4
`endif
`ifndef PKT_HEAD_WIDTH
`define PKT_HEAD_WIDTH 64
`endif
`ifndef PKT_DATA_WIDTH
`define PKT_DATA_WIDTH 256
`endif

interface recv_buffer_delete_arbiter_if #(
  parameter int REQ_NUM    = 2,
  parameter int HEAD_W     = `QP_NUM_LOG + `PSN_WIDTH + `RECV_BUFFER_SLOT_NUM_LOG,
  parameter int PKT_HEAD_W = `PKT_HEAD_WIDTH,
  parameter int PKT_DATA_W = `PKT_DATA_WIDTH
);
  // requester side: delete requests in
  logic [REQ_NUM-1:0]        iv_req_valid;
  logic [REQ_NUM*HEAD_W-1:0] iv_req_head;
  logic [REQ_NUM-1:0]        ov_req_ready;
  // packet buffer side: delete request out
  logic                      o_delete_req_valid;
  logic [HEAD_W-1:0]         ov_delete_req_head;
  logic                      i_delete_req_ready;
  // packet buffer side: multi-beat response in
  logic                      i_delete_resp_valid;
  logic                      i_delete_resp_start;
  logic                      i_delete_resp_last;
  logic [PKT_HEAD_W-1:0]     iv_delete_resp_head;
  logic [PKT_DATA_W-1:0]     iv_delete_resp_data;
  logic                      o_delete_resp_ready;
  // requester side: steered response out
  logic [REQ_NUM-1:0]        ov_resp_valid;
  logic [PKT_HEAD_W-1:0]     ov_resp_head;
  logic [PKT_DATA_W-1:0]     ov_resp_data;
  logic                      o_resp_start;
  logic                      o_resp_last;
  logic [REQ_NUM-1:0]        iv_resp_ready;

  modport slave (
    input  iv_req_valid, iv_req_head, i_delete_req_ready,
    input  i_delete_resp_valid, i_delete_resp_start, i_delete_resp_last,
    input  iv_delete_resp_head, iv_delete_resp_data, iv_resp_ready,
    output ov_req_ready, o_delete_req_valid, ov_delete_req_head,
    output o_delete_resp_ready, ov_resp_valid, ov_resp_head, ov_resp_data,
    output o_resp_start, o_resp_last
  );

  modport master (
    output iv_req_valid, iv_req_head, i_delete_req_ready,
    output i_delete_resp_valid, i_delete_resp_start, i_delete_resp_last,
    output iv_delete_resp_head, iv_delete_resp_data, iv_resp_ready,
    input  ov_req_ready, o_delete_req_valid, ov_delete_req_head,
    input  o_delete_resp_ready, ov_resp_valid, ov_resp_head, ov_resp_data,
    input  o_resp_start, o_resp_last
  );
endinterface

// File: rtl/recv_buffer_delete_arbiter.sv
// Round-robin arbiter sharing the packet buffer's single delete port among
// REQ_NUM requesters. One delete in flight; the multi-beat response is steered
// back to the winner only, and a watchdog frees the port if beats stop coming.
`ifndef QP_NUM_LOG
`define QP_NUM_LOG 12
`endif
`ifndef PSN_WIDTH
`define PSN_WIDTH 24
`endif
`ifndef RECV_BUFFER_SLOT_NUM_LOG
`define RECV_BUFFER_SLOT_NUM_LOG 4
`endif
`ifndef PKT_HEAD_WIDTH
`define PKT_HEAD_WIDTH 64
`endif
`ifndef PKT_DATA_WIDTH
`define PKT_DATA_WIDTH 256
`endif

module recv_buffer_delete_arbiter #(
  parameter int REQ_NUM     = 2,
  parameter int HEAD_W      = `QP_NUM_LOG + `PSN_WIDTH + `RECV_BUFFER_SLOT_NUM_LOG,
  parameter int PKT_HEAD_W  = `PKT_HEAD_WIDTH,
  parameter int PKT_DATA_W  = `PKT_DATA_WIDTH,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  recv_buffer_delete_arbiter_if.slave   bus,
  output logic                          o_timeout_err,
  output logic [15:0]                   ov_timeout_cnt
);

  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    rr_ptr, rr_nxt;
  logic [PTR_W-1:0]    grant, grant_nxt;
  logic [HEAD_W-1:0]   head_q, head_nxt;
  logic [WD_W-1:0]     wd_cnt, wd_nxt;
  logic                to_fire;

  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    cand;

  logic [REQ_NUM-1:0]  req_ready;
  logic                del_vld;
  logic                resp_rdy;
  logic [REQ_NUM-1:0]  resp_vld;
  logic                in_resp;

  // per-requester view of the flat head bus
  logic [HEAD_W-1:0]   req_head [REQ_NUM];

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_head
    assign req_head[g] = bus.iv_req_head[g*HEAD_W +: HEAD_W];
  end

  // next round-robin position after the given requester, wrapping at REQ_NUM
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == REQ_NUM - 1) ? '0 : p + 1'b1;
  endfunction

  // round-robin search: first valid requester at or after rr_ptr
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % REQ_NUM);
      if (!win_found && bus.iv_req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // next-state, handshakes and watchdog
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    grant_nxt = grant;
    head_nxt  = head_q;
    wd_nxt    = wd_cnt;
    to_fire   = 1'b0;
    req_ready = '0;
    del_vld   = 1'b0;
    resp_rdy  = 1'b0;
    resp_vld  = '0;
    case (state)
      ARB_IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          head_nxt           = req_head[win_idx];
          grant_nxt          = win_idx;
          state_nxt          = ARB_REQ;
        end
      end
      ARB_REQ: begin
        // head_q is frozen here, so late changes on iv_req_head are ignored
        del_vld = 1'b1;
        if (bus.i_delete_req_ready) begin
          state_nxt = ARB_RESP;
          wd_nxt    = '0;
        end
      end
      ARB_RESP: begin
        resp_vld[grant] = bus.i_delete_resp_valid;
        resp_rdy        = bus.iv_resp_ready[grant];
        if (bus.i_delete_resp_valid) begin
          // a presented beat, even one stalled by the requester, is progress
          wd_nxt = '0;
          if (resp_rdy && bus.i_delete_resp_last) begin
            state_nxt = ARB_IDLE;
            rr_nxt    = ptr_inc(grant);
          end
        end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
          // buffer went silent: abandon the transaction and move on
          to_fire   = 1'b1;
          state_nxt = ARB_IDLE;
          rr_nxt    = ptr_inc(grant);
          wd_nxt    = '0;
        end else begin
          wd_nxt = wd_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ARB_IDLE;
      rr_ptr         <= '0;
      grant          <= '0;
      head_q         <= '0;
      wd_cnt         <= '0;
      o_timeout_err  <= 1'b0;
      ov_timeout_cnt <= '0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_nxt;
      grant         <= grant_nxt;
      head_q        <= head_nxt;
      wd_cnt        <= wd_nxt;
      o_timeout_err <= to_fire;
      if (to_fire && ov_timeout_cnt != 16'hFFFF)
        ov_timeout_cnt <= ov_timeout_cnt + 16'd1;
    end
  end

  assign in_resp = (state == ARB_RESP);

  // ready is combinational from valid, so hold it low while reset is applied
  assign bus.ov_req_ready        = rst ? req_ready : '0;
  assign bus.o_delete_req_valid  = del_vld;
  assign bus.ov_delete_req_head  = del_vld ? head_q : '0;
  assign bus.o_delete_resp_ready = resp_rdy;
  assign bus.ov_resp_valid       = resp_vld;
  // response payload passes through only while a response is owned
  assign bus.ov_resp_head        = in_resp ? bus.iv_delete_resp_head : '0;
  assign bus.ov_resp_data        = in_resp ? bus.iv_delete_resp_data : '0;
  assign bus.o_resp_start        = in_resp & bus.i_delete_resp_start;
  assign bus.o_resp_last         = in_resp & bus.i_delete_resp_last;

endmodule

// File: tb/tb_recv_buffer_delete_arbiter.sv
// Scoreboard bench for recv_buffer_delete_arbiter: stimulus pushes expected
// grants, delete heads, response beats and watchdog counts into queues; a
// negedge monitor pops and compares whenever the DUT presents one of them.
module tb_recv_buffer_delete_arbiter;
  localparam int RN  = 2;
  localparam int HW  = 40;
  localparam int PHW = 16;
  localparam int PDW = 32;
  localparam int TO  = 4;

  typedef struct {
    logic [RN-1:0]  vld;
    logic [PHW-1:0] head;
    logic [PDW-1:0] data;
    logic           start;
    logic           last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        to_err;
  logic [15:0] to_cnt;

  int vecs = 0;
  int errs = 0;
  int to_exp = 0;

  logic [RN-1:0] gq [$];
  logic [HW-1:0] hq [$];
  beat_t         bq [$];
  int            tq [$];

  recv_buffer_delete_arbiter_if #(.REQ_NUM(RN), .HEAD_W(HW), .PKT_HEAD_W(PHW), .PKT_DATA_W(PDW)) bus ();

  recv_buffer_delete_arbiter #(
    .REQ_NUM(RN), .HEAD_W(HW), .PKT_HEAD_W(PHW), .PKT_DATA_W(PDW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_timeout_err(to_err), .ov_timeout_cnt(to_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t mk_beat(input int k, input int i, input int n);
    beat_t b;
    b.vld   = RN'(1 << k);
    b.head  = PHW'(32'hB000 + k * 256 + i);
    b.data  = 32'hDA7A_0000 + 32'(k * 256 + i);
    b.start = (i == 0);
    b.last  = (i == n - 1);
    return b;
  endfunction

  task automatic apply_beat(input beat_t b);
    bus.i_delete_resp_valid = 1'b1;
    bus.i_delete_resp_start = b.start;
    bus.i_delete_resp_last  = b.last;
    bus.iv_delete_resp_head = b.head;
    bus.iv_delete_resp_data = b.data;
  endtask

  task automatic clear_resp();
    bus.i_delete_resp_valid = 1'b0;
    bus.i_delete_resp_start = 1'b0;
    bus.i_delete_resp_last  = 1'b0;
    bus.iv_delete_resp_head = '0;
    bus.iv_delete_resp_data = '0;
  endtask

  // one full delete: request, optional downstream stall, nb beats (0 = no
  // response, watchdog expected), optional requester stall on beat stall_at
  task automatic txn(input logic [RN-1:0] vmask, input logic [HW-1:0] h0, input logic [HW-1:0] h1,
                     input int k, input int nb, input int stall_at, input int stall_len,
                     input int req_stall, input bit keep);
    logic [HW-1:0] eh;
    logic [RN-1:0] oh;
    beat_t         b;
    int            fired;
    eh = (k == 1) ? h1 : h0;
    oh = RN'(1 << k);
    bus.iv_req_valid = vmask;
    bus.iv_req_head  = {h1, h0};
    gq.push_back(oh);
    hq.push_back(eh);
    tick();
    if (!keep) bus.iv_req_valid = '0;
    if (req_stall > 0) begin
      bus.i_delete_req_ready = 1'b0;
      for (int c = 0; c < req_stall; c++) begin
        bus.iv_req_head = {h1 ^ HW'(c + 1), h0 ^ HW'(c + 1)};
        @(negedge clk);
        chk("stall_req_valid", 64'(bus.o_delete_req_valid), 64'd1);
        chk("stall_req_head", 64'(bus.ov_delete_req_head), 64'(eh));
        tick();
      end
      bus.i_delete_req_ready = 1'b1;
    end else begin
      @(negedge clk);
      chk("req_valid_t1", 64'(bus.o_delete_req_valid), 64'd1);
    end
    tick();
    if (nb == 0) begin
      to_exp++;
      tq.push_back(to_exp);
      fired = -1;
      for (int c = 0; c < 3 * TO && fired < 0; c++) begin
        @(negedge clk);
        if (to_err) fired = c;
        else tick();
      end
      chk("wd_latency", 64'(fired), 64'(TO));
      if (fired >= 0) tick();
    end else begin
      bus.iv_resp_ready = '1;
      for (int i = 0; i < nb; i++) begin
        b = mk_beat(k, i, nb);
        apply_beat(b);
        if (i == stall_at) begin
          bus.iv_resp_ready = ~oh;
          for (int c = 0; c < stall_len; c++) begin
            @(negedge clk);
            chk("bp_resp_ready", 64'(bus.o_delete_resp_ready), 64'd0);
            chk("bp_resp_valid", 64'(bus.ov_resp_valid), 64'(oh));
            chk("bp_resp_data", 64'(bus.ov_resp_data), 64'(b.data));
            tick();
          end
          bus.iv_resp_ready = '1;
        end
        bq.push_back(b);
        tick();
      end
      clear_resp();
    end
  endtask

  // monitor: pop and compare whenever the DUT presents something
  always @(negedge clk) begin
    logic [RN-1:0] g;
    logic [HW-1:0] h;
    beat_t         b;
    int            t;
    if (bus.ov_req_ready != '0) begin
      if (gq.size() == 0) chk("unexpected_grant", 64'(bus.ov_req_ready), 64'd0);
      else begin
        g = gq.pop_front();
        chk("grant", 64'(bus.ov_req_ready), 64'(g));
      end
    end
    if (bus.o_delete_req_valid && bus.i_delete_req_ready) begin
      if (hq.size() == 0) chk("unexpected_delete_req", 64'(bus.ov_delete_req_head), 64'd0);
      else begin
        h = hq.pop_front();
        chk("delete_head", 64'(bus.ov_delete_req_head), 64'(h));
      end
    end
    if ((bus.ov_resp_valid != '0) && bus.o_delete_resp_ready) begin
      if (bq.size() == 0) chk("unexpected_beat", 64'(bus.ov_resp_valid), 64'd0);
      else begin
        b = bq.pop_front();
        chk("beat_valid", 64'(bus.ov_resp_valid), 64'(b.vld));
        chk("beat_head", 64'(bus.ov_resp_head), 64'(b.head));
        chk("beat_data", 64'(bus.ov_resp_data), 64'(b.data));
        chk("beat_start", 64'(bus.o_resp_start), 64'(b.start));
        chk("beat_last", 64'(bus.o_resp_last), 64'(b.last));
      end
    end
    if (to_err) begin
      if (tq.size() == 0) chk("unexpected_timeout", 64'(to_cnt), 64'd0);
      else begin
        t = tq.pop_front();
        chk("timeout_cnt", 64'(to_cnt), 64'(t));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    beat_t b;
    // reset with busy-looking inputs: every output must still read 0
    rst = 1'b0;
    bus.iv_req_valid       = 2'b11;
    bus.iv_req_head        = {40'h1, 40'h2};
    bus.i_delete_req_ready = 1'b1;
    bus.iv_resp_ready      = '1;
    bus.i_delete_resp_valid = 1'b1;
    bus.i_delete_resp_start = 1'b1;
    bus.i_delete_resp_last  = 1'b1;
    bus.iv_delete_resp_head = 16'h1234;
    bus.iv_delete_resp_data = 32'h5678_9ABC;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.ov_req_ready), 64'd0);
    chk("rst_del_valid", 64'(bus.o_delete_req_valid), 64'd0);
    chk("rst_del_head", 64'(bus.ov_delete_req_head), 64'd0);
    chk("rst_resp_ready", 64'(bus.o_delete_resp_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.ov_resp_valid), 64'd0);
    chk("rst_resp_head", 64'(bus.ov_resp_head), 64'd0);
    chk("rst_resp_data", 64'(bus.ov_resp_data), 64'd0);
    chk("rst_to_err", 64'(to_err), 64'd0);
    chk("rst_to_cnt", 64'(to_cnt), 64'd0);
    bus.iv_req_valid = '0;
    clear_resp();
    tick();
    rst = 1'b1;
    tick();
    tick();

    // single requester, 3 beats
    txn(2'b01, 40'h00A_000005_3, 40'h0, 0, 3, -1, 0, 0, 1'b0);
    @(negedge clk);
    chk("idle_del_valid", 64'(bus.o_delete_req_valid), 64'd0);
    chk("idle_resp_ready", 64'(bus.o_delete_resp_ready), 64'd0);
    tick();

    // contention: rr_ptr is 1 after the first grant, so 1,0,1,0
    txn(2'b11, 40'h11_0000_0010, 40'h22_0000_0020, 1, 2, -1, 0, 0, 1'b1);
    txn(2'b11, 40'h11_0000_0011, 40'h22_0000_0021, 0, 2, -1, 0, 0, 1'b1);
    txn(2'b11, 40'h11_0000_0012, 40'h22_0000_0022, 1, 2, -1, 0, 0, 1'b1);
    txn(2'b11, 40'h11_0000_0013, 40'h22_0000_0023, 0, 2, -1, 0, 0, 1'b0);
    tick();

    // requester backpressure longer than the watchdog window
    txn(2'b10, 40'h0, 40'h33_0000_0030, 1, 4, 1, 5, 0, 1'b0);
    tick();

    // downstream stall with head changes on the request bus
    txn(2'b01, 40'h44_0000_0040, 40'h0, 0, 2, -1, 0, 10, 1'b0);
    tick();

    // watchdog: no beats after accept, then the other requester wins
    txn(2'b11, 40'h55_0000_0050, 40'h55_0000_0051, 1, 0, -1, 0, 0, 1'b0);
    @(negedge clk);
    chk("to_cnt_after_wd", 64'(to_cnt), 64'd1);
    tick();
    txn(2'b11, 40'h55_0000_0052, 40'h55_0000_0053, 0, 1, -1, 0, 0, 1'b0);
    tick();

    // reset during beat 1 of requester 1's response
    bus.iv_req_valid = 2'b10;
    bus.iv_req_head  = {40'h66_0000_0006, 40'h0};
    gq.push_back(2'b10);
    hq.push_back(40'h66_0000_0006);
    tick();
    bus.iv_req_valid  = '0;
    bus.iv_resp_ready = '1;
    tick();
    b = mk_beat(1, 0, 3);
    apply_beat(b);
    bq.push_back(b);
    tick();
    b = mk_beat(1, 1, 3);
    apply_beat(b);
    bus.iv_req_valid = 2'b11;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_req_ready", 64'(bus.ov_req_ready), 64'd0);
    chk("mid_rst_resp_valid", 64'(bus.ov_resp_valid), 64'd0);
    chk("mid_rst_resp_ready", 64'(bus.o_delete_resp_ready), 64'd0);
    chk("mid_rst_resp_data", 64'(bus.ov_resp_data), 64'd0);
    chk("mid_rst_resp_last", 64'(bus.o_resp_last), 64'd0);
    chk("mid_rst_del_valid", 64'(bus.o_delete_req_valid), 64'd0);
    chk("mid_rst_to_err", 64'(to_err), 64'd0);
    chk("mid_rst_to_cnt", 64'(to_cnt), 64'd0);
    bus.iv_req_valid = '0;
    clear_resp();
    tick();
    rst = 1'b1;
    tick();
    // rr_ptr back at 0: with both valid, requester 0 wins
    txn(2'b11, 40'h77_0000_0070, 40'h77_0000_0071, 0, 1, -1, 0, 0, 1'b0);
    @(negedge clk);
    chk("to_cnt_after_rst", 64'(to_cnt), 64'd0);
    tick();
    tick();

    chk("grant_queue_drained", 64'(gq.size()), 64'd0);
    chk("head_queue_drained", 64'(hq.size()), 64'd0);
    chk("beat_queue_drained", 64'(bq.size()), 64'd0);
    chk("timeout_queue_drained", 64'(tq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
